// File: rtl/bicubic_accum_if.sv
// Stream interface between a bicubic multiplier bank (master) and its
// accumulator (slave): product beats in, clamped pixels out.
interface bicubic_accum_if #(
  parameter int TAPS = 4
);
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_product;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_pixel;
  logic             out_sat;
  logic [TAP_W-1:0] tap_idx;

  modport master (
    output in_valid, in_product, in_sign, out_ready,
    input  in_ready, out_valid, out_pixel, out_sat, tap_idx
  );

  modport slave (
    input  in_valid, in_product, in_sign, out_ready,
    output in_ready, out_valid, out_pixel, out_sat, tap_idx
  );
endinterface

// File: rtl/bicubic_accum.sv
// Sums TAPS sign-magnitude tap products per output sample and clamps the
// result to an unsigned 8-bit pixel behind a valid/ready output register.
module bicubic_accum #(
  parameter int TAPS  = 4,
  parameter int ACC_W = 11
) (
  input  logic            clk,
  input  logic            rst,
  bicubic_accum_if.slave  bus
);

  localparam int                      TAP_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0]        LAST_TAP = TAP_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'(255);

  generate
    if (TAPS < 2 || (TAPS & (TAPS - 1)) != 0 || ACC_W < 9 + $clog2(TAPS)) begin : g_bad_param
      $error("bicubic_accum: TAPS must be a power of two >= 2 and ACC_W >= 9+log2(TAPS)");
    end
  endgenerate

  function automatic logic [7:0] clamp_pixel(input logic signed [ACC_W-1:0] s);
    if (s[ACC_W-1])
      return 8'd0;
    else if (s > PIX_MAX)
      return 8'd255;
    else
      return s[7:0];
  endfunction

  function automatic logic is_sat(input logic signed [ACC_W-1:0] s);
    return s[ACC_W-1] | (s > PIX_MAX);
  endfunction

  logic signed [ACC_W-1:0] acc_p0;
  logic        [TAP_W-1:0] tap_p0;
  logic signed [ACC_W-1:0] mag;
  logic signed [ACC_W-1:0] value;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic                    vld_p1;
  logic [7:0]              pixel_p1;
  logic                    sat_p1;
  logic                    ready;
  logic                    take;
  logic                    last_tap;

  // Stage 0: signed conversion and running sum; the first tap overwrites acc.
  // Negating a zero magnitude yields zero, so negative zero needs no special case.
  always_comb begin
    mag   = $signed({{(ACC_W-8){1'b0}}, bus.in_product});
    value = bus.in_sign ? -mag : mag;
    base  = (tap_p0 == '0) ? '0 : acc_p0;
    sum   = base + value;
  end

  assign ready    = ~(vld_p1 & ~bus.out_ready);
  assign take     = bus.in_valid & ready;
  assign last_tap = (tap_p0 == LAST_TAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0 <= '0;
      tap_p0 <= '0;
    end else if (take) begin
      acc_p0 <= sum;
      tap_p0 <= last_tap ? '0 : tap_p0 + TAP_W'(1);
    end
  end

  // Stage 1: output register; a new result may replace one being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      pixel_p1 <= '0;
      sat_p1   <= 1'b0;
    end else if (take && last_tap) begin
      vld_p1   <= 1'b1;
      pixel_p1 <= clamp_pixel(sum);
      sat_p1   <= is_sat(sum);
    end else if (bus.out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_pixel = pixel_p1;
  assign bus.out_sat   = sat_p1;
  assign bus.tap_idx   = tap_p0;

endmodule

// File: tb/tb_bicubic_accum.sv
// Randomized and directed bench for bicubic_accum against a queue-based
// sum-and-clamp reference model.
module tb_bicubic_accum;
  localparam int TAPS  = 4;
  localparam int ACC_W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bicubic_accum_if #(.TAPS(TAPS)) bus ();

  bicubic_accum #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int q_pix[$];
  int q_sat[$];
  int grp_sum  = 0;
  int grp_cnt  = 0;
  int accepted = 0;
  int drained  = 0;

  // last sampled outputs
  int s_valid, s_pixel, s_sat, s_ready, s_tap;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int ref_clamp(input int s);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic model_reset();
    q_pix.delete();
    q_sat.delete();
    grp_sum = 0;
    grp_cnt = 0;
  endtask

  // One clock cycle: drive at negedge, sample before the rising edge,
  // compare against the model and advance it for the coming edge.
  task automatic step(input bit v, input int mag, input bit sg, input bit ordy);
    bit exp_ready;
    @(negedge clk);
    bus.in_valid   = v;
    bus.in_product = 8'(mag);
    bus.in_sign    = sg;
    bus.out_ready  = ordy;
    #1;
    s_valid = int'(bus.out_valid);
    s_pixel = int'(bus.out_pixel);
    s_sat   = int'(bus.out_sat);
    s_ready = int'(bus.in_ready);
    s_tap   = int'(bus.tap_idx);
    exp_ready = !(q_pix.size() > 0 && !ordy);
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(q_pix.size() > 0));
    check("tap_idx", 32'(bus.tap_idx), 32'(grp_cnt));
    if (q_pix.size() > 0 && ordy) begin
      check("out_pixel", 32'(bus.out_pixel), 32'(q_pix.pop_front()));
      check("out_sat", 32'(bus.out_sat), 32'(q_sat.pop_front()));
      drained++;
    end
    if (v && exp_ready) begin
      accepted++;
      grp_sum += sg ? -mag : mag;
      grp_cnt++;
      if (grp_cnt == TAPS) begin
        q_pix.push_back(ref_clamp(grp_sum));
        q_sat.push_back((grp_sum < 0 || grp_sum > 255) ? 1 : 0);
        grp_sum = 0;
        grp_cnt = 0;
      end
    end
  endtask

  initial begin
    int held_pix;
    int acc0;
    int cycles;
    bus.in_valid   = 1'b0;
    bus.in_product = 8'd0;
    bus.in_sign    = 1'b0;
    bus.out_ready  = 1'b0;

    // reset state
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_pixel", 32'(bus.out_pixel), 32'd0);
    check("rst_sat", 32'(bus.out_sat), 32'd0);
    check("rst_tap", 32'(bus.tap_idx), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    #11 rst = 1'b0;

    // basic group: -10 +100 +50 -5 = 135
    step(1, 10, 1, 1);
    step(1, 100, 0, 1);
    step(1, 50, 0, 1);
    step(1, 5, 1, 1);
    step(0, 0, 0, 1);
    check("t1_valid", 32'(s_valid), 32'd1);
    check("t1_pix", 32'(s_pixel), 32'd135);
    check("t1_sat", 32'(s_sat), 32'd0);
    check("t1_tap", 32'(s_tap), 32'd0);

    // clamp high, then clamp low with a negative zero
    step(1, 200, 0, 1); step(1, 200, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    check("t2_hi_pix", 32'(s_pixel), 32'd255);
    check("t2_hi_sat", 32'(s_sat), 32'd1);
    step(1, 50, 1, 1); step(1, 10, 0, 1); step(1, 0, 0, 1); step(1, 0, 1, 1);
    step(0, 0, 0, 1);
    check("t2_lo_pix", 32'(s_pixel), 32'd0);
    check("t2_lo_sat", 32'(s_sat), 32'd1);
    step(1, 3, 0, 1); step(1, 0, 1, 1); step(1, 0, 1, 1); step(1, 0, 1, 1);
    step(0, 0, 0, 1);
    check("t2_negzero_pix", 32'(s_pixel), 32'd3);

    // back-to-back groups with no bubble
    acc0 = accepted;
    for (int i = 0; i < 2 * TAPS; i++) begin
      step(1, 20 + i, 0, 1);
      check("t3_ready", 32'(s_ready), 32'd1);
    end
    check("t3_accepted", 32'(accepted - acc0), 32'(2 * TAPS));
    step(0, 0, 0, 1);
    check("t3_pix2", 32'(s_pixel), 32'(24 + 25 + 26 + 27));

    // held result with out_ready low
    for (int i = 0; i < TAPS; i++) step(1, 30, 0, 1);
    step(1, 9, 0, 0);
    held_pix = s_pixel;
    check("t4_held_val", 32'(held_pix), 32'd120);
    for (int i = 0; i < 4; i++) begin
      step(1, 9, 0, 0);
      check("t4_stall", 32'(s_ready), 32'd0);
      check("t4_hold", 32'(s_pixel), 32'(held_pix));
    end
    step(1, 9, 0, 1);
    check("t4_release", 32'(s_ready), 32'd1);
    for (int i = 0; i < TAPS - 1; i++) step(1, 9, 0, 1);
    step(0, 0, 0, 1);
    check("t4_next_pix", 32'(s_pixel), 32'd36);

    // asynchronous reset in the middle of a group
    step(1, 77, 0, 1);
    step(1, 77, 0, 1);
    @(posedge clk);
    #2;
    check("t5_tap_before", 32'(bus.tap_idx), 32'd2);
    rst = 1'b1;
    #1;
    check("t5_rst_tap", 32'(bus.tap_idx), 32'd0);
    check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t5_rst_pixel", 32'(bus.out_pixel), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < TAPS; i++) step(1, 1, 0, 1);
    step(0, 0, 0, 1);
    check("t5_pix", 32'(s_pixel), 32'd4);

    // randomized stalls, signs and magnitudes
    drained = 0;
    cycles  = 0;
    while (drained < 3000 && cycles < 60000) begin
      step(($urandom_range(3) != 0), int'($urandom_range(255)), 1'($urandom_range(1)),
           ($urandom_range(3) != 0));
      cycles++;
    end
    check("rand_groups_done", 32'(drained >= 3000), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    check("rand_queue_empty", 32'(q_pix.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
